ps2_keyboard_rx: RTL and testbench

PS/2 keyboard receive front-end in the `clk25` domain, sitting between the board-level PS/2 pins (`ps2_clk`/`ps2_din`, emulated over the USB D+/D- pair) and the Apple 1 keyboard logic. It synchronises and glitch-filters the raw lines, deframes 11-bit PS/2 frames, checks odd parity, stop bit and inter-bit timeout, and folds the `E0`/`F0` prefixes into flags. It delivers complete scancodes through a small valid/ready FIFO.

---
 rtl/ps2_keyboard_rx.sv | 224 ++++++++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receive front-end (clk25 domain).
// Synchronises and glitch-filters the raw PS/2 lines, deframes 11-bit frames,
// checks start/parity/stop/timeout, folds E0/F0 prefixes into flags and
// delivers complete scancodes through a small valid/ready FIFO.
module ps2_keyboard_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 5000,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic       clk25,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_din,
    output logic       code_valid,
    output logic [7:0] code_data,
    output logic       code_break,
    output logic       code_ext,
    input  logic       code_ready,
    output logic       frame_err,
    output logic       overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0]    FILT_LAST = 8'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_ONE    = TW'(1);
    localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    // Input conditioning
    logic r_clk_s1, r_clk_s2, r_din_s1, r_din_s2;
    logic r_filt_clk;
    logic [7:0] r_filt_cnt;
    logic r_fall;

    // Deframer
    logic [1:0]    r_state;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_parity;
    logic [TW-1:0] r_to_cnt;
    logic          r_frame_err;
    logic          r_brk_pend, r_ext_pend;
    logic          r_push_req;
    logic [7:0]    r_push_code;
    logic          r_push_brk, r_push_ext;

    // FIFO
    logic [9:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr, r_rd_ptr;
    logic        r_overflow;

    logic       w_frame_ok;
    logic       w_empty, w_full, w_pop, w_push, w_drop;
    logic [9:0] w_head;

    // Two-flop synchronisers; lines idle high so reset to 1 avoids a false edge.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_din_s1 <= 1'b1;
            r_din_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_din_s1 <= ps2_din;
            r_din_s2 <= r_din_s1;
        end
    end

    // Filtered clock follows the synchronised clock only after FILTER_LEN steady cycles.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_filt_clk <= 1'b1;
            r_filt_cnt <= 8'd0;
            r_fall     <= 1'b0;
        end else begin
            r_fall <= 1'b0;
            if (r_clk_s2 != r_filt_clk) begin
                if (r_filt_cnt == FILT_LAST) begin
                    r_filt_clk <= r_clk_s2;
                    r_filt_cnt <= 8'd0;
                    // Old level high means this change is a falling edge
                    r_fall     <= r_filt_clk;
                end else begin
                    r_filt_cnt <= r_filt_cnt + 8'd1;
                end
            end else begin
                r_filt_cnt <= 8'd0;
            end
        end
    end

    // Odd parity over data plus parity bit, and a high stop bit.
    assign w_frame_ok = r_din_s2 & (^{r_shift, r_parity});

    // Frame deframer, inter-bit timeout and prefix folding.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'd0;
            r_parity    <= 1'b0;
            r_to_cnt    <= '0;
            r_frame_err <= 1'b0;
            r_brk_pend  <= 1'b0;
            r_ext_pend  <= 1'b0;
            r_push_req  <= 1'b0;
            r_push_code <= 8'd0;
            r_push_brk  <= 1'b0;
            r_push_ext  <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_push_req  <= 1'b0;
            if (r_fall) begin
                r_to_cnt <= '0;
                case (r_state)
                    ST_IDLE: begin
                        if (!r_din_s2) begin
                            r_state   <= ST_DATA;
                            r_bit_cnt <= 3'd0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_brk_pend  <= 1'b0;
                            r_ext_pend  <= 1'b0;
                        end
                    end
                    ST_DATA: begin
                        r_shift   <= {r_din_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        r_parity <= r_din_s2;
                        r_state  <= ST_STOP;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        if (w_frame_ok) begin
                            if (r_shift == 8'hE0) begin
                                r_ext_pend <= 1'b1;
                            end else if (r_shift == 8'hF0) begin
                                r_brk_pend <= 1'b1;
                            end else begin
                                r_push_req  <= 1'b1;
                                r_push_code <= r_shift;
                                r_push_brk  <= r_brk_pend;
                                r_push_ext  <= r_ext_pend;
                                r_brk_pend  <= 1'b0;
                                r_ext_pend  <= 1'b0;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            r_brk_pend  <= 1'b0;
                            r_ext_pend  <= 1'b0;
                        end
                    end
                endcase
            end else if (r_state != ST_IDLE) begin
                if (r_to_cnt == TO_LAST) begin
                    r_frame_err <= 1'b1;
                    r_state     <= ST_IDLE;
                    r_to_cnt    <= '0;
                    r_shift     <= 8'd0;
                    r_brk_pend  <= 1'b0;
                    r_ext_pend  <= 1'b0;
                end else begin
                    r_to_cnt <= r_to_cnt + TO_ONE;
                end
            end
            if (w_drop) begin
                r_brk_pend <= 1'b0;
                r_ext_pend <= 1'b0;
            end
        end
    end

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = !w_empty && code_ready;
    // A simultaneous pop frees the slot the push lands in
    assign w_push  = r_push_req && (!w_full || w_pop);
    assign w_drop  = r_push_req && w_full && !w_pop;

    // Scancode FIFO storage, pointers and overflow pulse.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i] <= 10'd0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_drop;
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= {r_push_code, r_push_brk, r_push_ext};
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
    assign code_valid = !w_empty;
    assign code_data  = w_head[9:2];
    assign code_break = w_head[1];
    assign code_ext   = w_head[0];
    assign frame_err  = r_frame_err;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: directed steps plus random frames,
// compared against a scancode-level model of the keyboard protocol.
module tb_ps2_keyboard_rx;

    localparam int HALF    = 30;
    localparam int TIMEOUT = 5000;
    localparam int DEPTH   = 4;

    logic       clk25 = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_din = 1'b1;
    logic       code_ready = 1'b0;
    logic       code_valid;
    logic [7:0] code_data;
    logic       code_break;
    logic       code_ext;
    logic       frame_err;
    logic       overflow;

    always #20 clk25 = ~clk25;

    ps2_keyboard_rx #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TIMEOUT),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk25      (clk25),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_din    (ps2_din),
        .code_valid (code_valid),
        .code_data  (code_data),
        .code_break (code_break),
        .code_ext   (code_ext),
        .code_ready (code_ready),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    int vectors = 0;
    int miscompares = 0;

    // Observed behaviour
    int         cyc = 0;
    int         err_seen = 0;
    int         ovf_seen = 0;
    logic [9:0] got_q[$];
    int         pop_cyc[$];

    // Reference model state
    int         exp_err = 0;
    int         exp_ovf = 0;
    logic [9:0] exp_q[$];
    bit         m_brk = 0;
    bit         m_ext = 0;
    int         m_occ = 0;

    always @(posedge clk25) cyc <= cyc + 1;

    always @(negedge clk25) begin
        if (rst_n) begin
            if (frame_err) err_seen <= err_seen + 1;
            if (overflow) ovf_seen <= ovf_seen + 1;
            if (code_valid && code_ready) begin
                got_q.push_back({code_data, code_break, code_ext});
                pop_cyc.push_back(cyc);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk25);
        #5;
    endtask

    // One PS/2 bit: data set while clock high, then a low phase.
    task automatic ps2_bit(input bit b, input bit glitch);
        ps2_din = b;
        if (glitch) begin
            tick(15);
            ps2_clk = 1'b0;
            tick(3);
            ps2_clk = 1'b1;
            tick(HALF - 18);
        end else begin
            tick(HALF);
        end
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input bit bad_par, input int nbits,
                              input bit glitch);
        logic [10:0] f;
        f = {1'b1, (~^code) ^ bad_par, code, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i], glitch);
        ps2_din = 1'b1;
        tick(2 * HALF);
    endtask

    // Protocol-level expectation for one complete frame.
    task automatic model_frame(input logic [7:0] code, input bit bad);
        if (bad) begin
            exp_err++;
            m_brk = 0;
            m_ext = 0;
        end else if (code == 8'hE0) begin
            m_ext = 1;
        end else if (code == 8'hF0) begin
            m_brk = 1;
        end else begin
            if (!code_ready && m_occ == DEPTH) begin
                exp_ovf++;
            end else begin
                exp_q.push_back({code, m_brk, m_ext});
                if (!code_ready) m_occ++;
            end
            m_brk = 0;
            m_ext = 0;
        end
    endtask

    task automatic xfer(input logic [7:0] code, input bit bad, input bit glitch);
        model_frame(code, bad);
        send_frame(code, bad, 11, glitch);
    endtask

    task automatic check_state(input string tag);
        int n;
        chk({tag, ":count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, ":entry"}, 32'(got_q[i]), 32'(exp_q[i]));
        chk({tag, ":frame_err"}, 32'(err_seen), 32'(exp_err));
        chk({tag, ":overflow"}, 32'(ovf_seen), 32'(exp_ovf));
        got_q.delete();
        exp_q.delete();
        pop_cyc.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ":valid"}, 32'(code_valid), 32'd0);
        chk({tag, ":data"}, 32'(code_data), 32'd0);
        chk({tag, ":break"}, 32'(code_break), 32'd0);
        chk({tag, ":ext"}, 32'(code_ext), 32'd0);
        chk({tag, ":frame_err"}, 32'(frame_err), 32'd0);
        chk({tag, ":overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        logic [7:0] code;
        int         r;
        bit         bad;

        tick(5);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick(10);
        code_ready = 1'b1;

        // Plain make code
        xfer(8'h1C, 0, 0);
        check_state("make_1C");

        // Both prefixes fold into a single entry
        xfer(8'hE0, 0, 0);
        xfer(8'hF0, 0, 0);
        xfer(8'h75, 0, 0);
        check_state("prefix_75");
        xfer(8'h1C, 0, 0);
        check_state("after_prefix");

        // Bad parity drops the frame and any pending prefix
        xfer(8'hE0, 0, 0);
        xfer(8'h1C, 1, 0);
        check_state("bad_parity");
        xfer(8'hF0, 0, 0);
        xfer(8'h1C, 0, 0);
        check_state("break_after_err");

        // Falling edge with data high is a bad start bit
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
        tick(2 * HALF);
        exp_err++;
        check_state("bad_start");

        // Clock stops after 4 data bits
        xfer(8'hF0, 0, 0);
        send_frame(8'h55, 0, 5, 0);
        tick(TIMEOUT + 10);
        exp_err++;
        m_brk = 0;
        m_ext = 0;
        check_state("timeout");
        xfer(8'h2A, 0, 0);
        check_state("after_timeout");

        // Fill the FIFO, overflow on the fifth code, then drain at full rate
        code_ready = 1'b0;
        m_occ = 0;
        xfer(8'h16, 0, 0);
        xfer(8'h1E, 0, 0);
        xfer(8'h26, 0, 0);
        xfer(8'h25, 0, 0);
        xfer(8'h2E, 0, 0);
        chk("ovf:pulses", 32'(ovf_seen), 32'(exp_ovf));
        chk("ovf:valid", 32'(code_valid), 32'd1);
        chk("ovf:head", 32'(code_data), 32'h16);
        code_ready = 1'b1;
        tick(10);
        chk("drain:pops", 32'(pop_cyc.size()), 32'd4);
        for (int i = 1; i < pop_cyc.size(); i++) begin
            chk("drain:burst", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd1);
        end
        chk("drain:valid", 32'(code_valid), 32'd0);
        check_state("overflow");
        m_occ = 0;

        // Short low glitches while idle and between bits are ignored
        repeat (3) begin
            ps2_clk = 1'b0;
            tick(3);
            ps2_clk = 1'b1;
            tick(20);
        end
        xfer(8'h1C, 0, 1);
        check_state("glitch");

        // Random frames with prefixes and occasional parity errors
        repeat (20) begin
            r = $urandom_range(0, 9);
            if (r < 2) code = 8'hE0;
            else if (r < 4) code = 8'hF0;
            else code = 8'($urandom);
            bad = ($urandom_range(0, 7) == 0);
            xfer(code, bad, 0);
            check_state("random");
        end
        m_brk = 0;
        m_ext = 0;
        xfer(8'h11, 0, 0);
        check_state("random_flush");

        // Reset mid-frame with a flagged entry waiting in the FIFO
        code_ready = 1'b0;
        xfer(8'hE0, 0, 0);
        xfer(8'hF0, 0, 0);
        xfer(8'h1C, 0, 0);
        chk("prereset:valid", 32'(code_valid), 32'd1);
        chk("prereset:head", 32'({code_data, code_break, code_ext}), 32'({8'h1C, 2'b11}));
        send_frame(8'h33, 0, 5, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        exp_q.delete();
        got_q.delete();
        pop_cyc.delete();
        m_brk = 0;
        m_ext = 0;
        m_occ = 0;
        tick(5);
        rst_n = 1'b1;
        code_ready = 1'b1;
        tick(10);
        xfer(8'h2A, 0, 0);
        check_state("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
